// File: rtl/pipe_run_ctrl_pkg.sv
// Shared types and constants for the pipeline run controller.
package pipe_run_ctrl_pkg;

  typedef enum logic [1:0] {
    StHalt  = 2'b00,
    StRun   = 2'b01,
    StStep  = 2'b10,
    StBurst = 2'b11
  } state_e;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_HALT  = 2'b11;

  // Breakpoint index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer; emits a one-cycle press
// pulse on each debounced rising edge of the raw button.
module btn_debounce #(
  parameter int unsigned DB_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYC);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYC - 1)) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run/step/burst/halt controller producing a pipeline clock enable.
// Breakpoint comparators exist only when PIPE_RUN_CTRL_BP_EN is defined.
module pipe_run_ctrl
  import pipe_run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NUM_BP = 4,
  parameter int unsigned DB_CYC = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step_button,
  input  logic [1:0]                    mode,
  input  logic [CNT_W-1:0]              step_count,
  input  logic [NUM_BP-1:0]             bp_en,
  input  logic [NUM_BP*PC_W-1:0]        bp_addr,
  input  logic [PC_W-1:0]               pc_fetch,
  output logic                          pipe_en,
  output logic                          halted,
  output logic                          bp_hit,
  output logic [idx_width(NUM_BP)-1:0]  bp_idx,
  output logic [CNT_W-1:0]              steps_done
);

  localparam int unsigned IDX_W = idx_width(NUM_BP);

  logic             press;
  state_e           state_q;
  state_e           start_state;
  logic             leave_halt;
  logic             bp_stop;
  logic             active;
  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] steps_q;

  btn_debounce #(
    .DB_CYC (DB_CYC)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_in (step_button),
    .press  (press)
  );

  assign active     = (state_q != StHalt);
  assign pipe_en    = active & ~bp_stop;
  assign halted     = ~active;
  assign steps_done = steps_q;

  always_comb begin
    leave_halt  = 1'b0;
    start_state = StHalt;
    if (state_q == StHalt && press) begin
      unique case (mode)
        MODE_RUN: begin
          leave_halt  = 1'b1;
          start_state = StRun;
        end
        MODE_STEP: begin
          leave_halt  = 1'b1;
          start_state = StStep;
        end
        MODE_BURST: begin
          if (step_count != '0) begin
            leave_halt  = 1'b1;
            start_state = StBurst;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StHalt;
      burst_q <= '0;
      steps_q <= '0;
    end else begin
      if (pipe_en && steps_q != '1) begin
        steps_q <= steps_q + CNT_W'(1);
      end
      unique case (state_q)
        StHalt: begin
          if (leave_halt) begin
            state_q <= start_state;
            steps_q <= '0;
            burst_q <= step_count;
          end
        end
        StRun: begin
          if (bp_stop || mode == MODE_HALT) state_q <= StHalt;
        end
        StStep: begin
          state_q <= StHalt;
        end
        StBurst: begin
          if (pipe_en) burst_q <= burst_q - CNT_W'(1);
          if (bp_stop || mode == MODE_HALT || burst_q == CNT_W'(1)) state_q <= StHalt;
        end
        default: state_q <= StHalt;
      endcase
    end
  end

`ifdef PIPE_RUN_CTRL_BP_EN
  logic             match;
  logic [IDX_W-1:0] match_idx;
  logic             first_q;
  logic             bp_hit_q;
  logic [IDX_W-1:0] bp_idx_q;

  // Lowest enabled index wins.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (!match && bp_en[i] && bp_addr[i*PC_W +: PC_W] == pc_fetch) begin
        match     = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  // first_q marks the first active cycle so execution can resume past a breakpoint.
  assign bp_stop = match & ~first_q & (state_q == StRun || state_q == StBurst);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q  <= 1'b1;
      bp_hit_q <= 1'b0;
      bp_idx_q <= '0;
    end else begin
      first_q <= (state_q == StHalt);
      if (leave_halt) begin
        bp_hit_q <= 1'b0;
      end else if (bp_stop) begin
        bp_hit_q <= 1'b1;
        bp_idx_q <= match_idx;
      end
    end
  end

  assign bp_hit = bp_hit_q;
  assign bp_idx = bp_idx_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc_fetch};
  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
  assign bp_idx    = '0;
`endif

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Scoreboard bench: each run episode (leave HALT .. return to HALT) is
// checked against an expected record queued when the stimulus is issued.
module tb_pipe_run_ctrl;

  localparam int DBC = 8;

  typedef struct {
    int en;
    int steps;
    int hit;
    int idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         step_button = 1'b0;
  logic [1:0]   mode = 2'b01;
  logic [15:0]  step_count = 16'd0;
  logic [3:0]   bp_en = 4'b0000;
  logic [127:0] bp_addr = '0;
  logic [31:0]  pc_fetch = 32'h30;
  logic         pipe_en;
  logic         halted;
  logic         bp_hit;
  logic [1:0]   bp_idx;
  logic [15:0]  steps_done;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t e;
  int   en_cnt = 0;
  logic prev_halted = 1'b1;
  logic mon_on = 1'b1;

  pipe_run_ctrl #(
    .PC_W   (32),
    .CNT_W  (16),
    .NUM_BP (4),
    .DB_CYC (DBC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .step_button (step_button),
    .mode        (mode),
    .step_count  (step_count),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc_fetch    (pc_fetch),
    .pipe_en     (pipe_en),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .bp_idx      (bp_idx),
    .steps_done  (steps_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: count enabled cycles, score the episode when HALT is re-entered.
  always @(negedge clk) begin
    if (!halted) begin
      en_cnt += int'(pipe_en);
    end else if (!prev_halted) begin
      if (mon_on) begin
        if (exp_q.size() == 0) begin
          check("unexpected_episode", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("episode_en_cycles", en_cnt, e.en);
          check("episode_steps_done", int'(steps_done), e.steps);
          check("episode_bp_hit", int'(bp_hit), e.hit);
          if (e.idx >= 0) check("episode_bp_idx", int'(bp_idx), e.idx);
        end
      end
      en_cnt = 0;
    end
    prev_halted = halted;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    while (!pipe_en && n < 200) begin
      cyc();
      n++;
    end
    check({name, "_en_seen"}, int'(pipe_en), 1);
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 200) begin
      cyc();
      n++;
    end
    check({name, "_halted"}, int'(halted), 1);
  endtask

  task automatic btn_release();
    step_button = 1'b0;
    repeat (DBC + 4) cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc();
    check("rst_pipe_en", int'(pipe_en), 0);
    check("rst_halted", int'(halted), 1);
    check("rst_bp_hit", int'(bp_hit), 0);
    check("rst_bp_idx", int'(bp_idx), 0);
    check("rst_steps_done", int'(steps_done), 0);
    rst = 1'b1;
    repeat (2) cyc();

    // Single step, clean press.
    mode = 2'b01;
    exp_q.push_back('{1, 1, 0, 0});
    step_button = 1'b1;
    wait_en("step");
    wait_halt("step");
    btn_release();

    // Bouncing press: five toggles, then stable high.
    exp_q.push_back('{1, 1, 0, 0});
    step_button = 1'b1; cyc();
    step_button = 1'b0; cyc();
    step_button = 1'b1; cyc();
    step_button = 1'b0; cyc();
    step_button = 1'b1;
    wait_en("bounce");
    wait_halt("bounce");
    repeat (DBC + 4) cyc();
    btn_release();

    // Burst of 7.
    mode = 2'b10;
    step_count = 16'd7;
    exp_q.push_back('{7, 7, 0, 0});
    step_button = 1'b1;
    wait_en("burst7");
    wait_halt("burst7");
    btn_release();

    // Burst of 0 stays halted and leaves steps_done untouched.
    step_count = 16'd0;
    step_button = 1'b1;
    repeat (DBC + 8) cyc();
    check("burst0_halted", int'(halted), 1);
    check("burst0_steps_done", int'(steps_done), 7);
    btn_release();

    // Burst of 3 aborted by mode 11 in its second enabled cycle.
    step_count = 16'd3;
    exp_q.push_back('{2, 2, 0, 0});
    step_button = 1'b1;
    wait_en("burst_abort");
    cyc();
    mode = 2'b11;
    wait_halt("burst_abort");
    btn_release();

    // Run halted by mode 11; breakpoint inputs must not stop it.
    mode = 2'b00;
    pc_fetch = 32'h40;
    bp_addr = {32'h40, 32'h40, 32'h40, 32'h40};
`ifdef PIPE_RUN_CTRL_BP_EN
    bp_en = 4'b0000;
`else
    bp_en = 4'b1111;
`endif
    exp_q.push_back('{4, 4, 0, 0});
    step_button = 1'b1;
    wait_en("run_halt");
    repeat (3) cyc();
    mode = 2'b11;
    wait_halt("run_halt");
    btn_release();

`ifdef PIPE_RUN_CTRL_BP_EN
    // Breakpoint 1 and 2 both at 0x40: index 1 wins.
    mode = 2'b00;
    pc_fetch = 32'h30;
    bp_en = 4'b0110;
    bp_addr = {32'h0, 32'h40, 32'h40, 32'h0};
    exp_q.push_back('{3, 3, 1, 1});
    step_button = 1'b1;
    wait_en("bp_hit");
    repeat (3) cyc();
    pc_fetch = 32'h40;
    #1;
    check("bp_comb_block", int'(pipe_en), 0);
    wait_halt("bp_hit");
    btn_release();

    // Resume: first cycle runs at 0x40, second stops again.
    exp_q.push_back('{1, 1, 1, 1});
    step_button = 1'b1;
    wait_en("bp_resume");
    wait_halt("bp_resume");
    btn_release();

    // Breakpoint beats mode 11 in the same cycle.
    pc_fetch = 32'h30;
    bp_en = 4'b0100;
    exp_q.push_back('{2, 2, 1, 2});
    step_button = 1'b1;
    wait_en("bp_prio");
    cyc();
    cyc();
    pc_fetch = 32'h40;
    mode = 2'b11;
    wait_halt("bp_prio");
    btn_release();

    // bp_hit clears once HALT is left.
    mode = 2'b00;
    pc_fetch = 32'h30;
    exp_q.push_back('{2, 2, 0, -1});
    step_button = 1'b1;
    wait_en("bp_clear");
    cyc();
    mode = 2'b11;
    wait_halt("bp_clear");
    btn_release();
`endif

    // Asynchronous reset in the middle of a run.
    mode = 2'b00;
    pc_fetch = 32'h30;
    bp_en = 4'b0000;
    step_button = 1'b1;
    wait_en("rst_mid");
    cyc();
    mon_on = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_pipe_en", int'(pipe_en), 0);
    check("rst_mid_halted", int'(halted), 1);
    check("rst_mid_bp_hit", int'(bp_hit), 0);
    check("rst_mid_bp_idx", int'(bp_idx), 0);
    check("rst_mid_steps_done", int'(steps_done), 0);
    step_button = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    repeat (DBC + 4) cyc();
    check("post_rst_halted", int'(halted), 1);
    mon_on = 1'b1;

    repeat (2) cyc();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
